// File: rtl/seg_bcd_monitor.sv
// seg_bcd_monitor
//   Receive-side checker for the two-digit active-low seven-segment bus driven
//   by the BCD counter. Captures the segment word, decodes both digits, rejects
//   illegal patterns, optionally debounces the value and checks that accepted
//   values advance by +1 mod 100.
//
// Parameters
//   STABLE_CYCLES  identical legal samples needed before a value is accepted (>=1)
//   ERR_CNT_W      width of the saturating error counter
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   seg_in     in   [6:0] ones, [13:7] tens; each {g,f,e,d,c,b,a}, active-low
//   sample_en  in   capture seg_in on this edge
//   bcd_out    out  last accepted value, {tens,ones} BCD
//   bin_out    out  last accepted value in binary (0..99)
//   valid      out  1-cycle pulse, bcd_out/bin_out updated
//   code_err   out  1-cycle pulse, illegal segment pattern captured
//   seq_err    out  1-cycle pulse, accepted value broke the +1 sequence while locked
//   locked     out  high in LOCKED state
//   err_count  out  saturating count of code_err + seq_err events
module seg_bcd_monitor #(
  parameter int unsigned STABLE_CYCLES = 1,
  parameter int unsigned ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [13:0]          seg_in,
  input  logic                 sample_en,
  output logic [7:0]           bcd_out,
  output logic [6:0]           bin_out,
  output logic                 valid,
  output logic                 code_err,
  output logic                 seq_err,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX = cnt_t'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQ      = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  // Returns {legal, digit}.
  function automatic logic [4:0] dec_digit(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1000000: r = {1'b1, 4'd0};
      7'b1111001: r = {1'b1, 4'd1};
      7'b0100100: r = {1'b1, 4'd2};
      7'b0110000: r = {1'b1, 4'd3};
      7'b0011001: r = {1'b1, 4'd4};
      7'b0010010: r = {1'b1, 4'd5};
      7'b0000010: r = {1'b1, 4'd6};
      7'b1111000: r = {1'b1, 4'd7};
      7'b0000000: r = {1'b1, 4'd8};
      7'b0010000: r = {1'b1, 4'd9};
      default:    r = {1'b0, 4'd0};
    endcase
    return r;
  endfunction

  // Stage 1 capture
  logic [13:0] seg_q;
  logic        samp_q;

  // Stage 2 state
  state_t               state_q, state_d;
  cnt_t                 cnt_q, cnt_d;
  logic [7:0]           prev_q, prev_d;
  logic [6:0]           ref_q, ref_d;
  logic [7:0]           bcd_q, bcd_d;
  logic [6:0]           bin_q, bin_d;
  logic                 valid_q, valid_d;
  logic                 cerr_q, cerr_d;
  logic                 serr_q, serr_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;

  logic [4:0] ones_dec, tens_dec;
  logic       legal;
  logic [7:0] smp_bcd;
  logic [6:0] smp_bin;
  logic [6:0] ref_inc;
  logic       accept;
  logic       err_inc;

  always_comb begin
    ones_dec = dec_digit(seg_q[6:0]);
    tens_dec = dec_digit(seg_q[13:7]);
    legal    = ones_dec[4] & tens_dec[4];
    smp_bcd  = {tens_dec[3:0], ones_dec[3:0]};
    // tens*10 = tens*8 + tens*2
    smp_bin  = ({3'b000, tens_dec[3:0]} << 3) + ({3'b000, tens_dec[3:0]} << 1)
             + {3'b000, ones_dec[3:0]};
    ref_inc  = (ref_q == 7'd99) ? 7'd0 : ref_q + 7'd1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    ref_d   = ref_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    valid_d = 1'b0;
    cerr_d  = 1'b0;
    serr_d  = 1'b0;
    err_inc = 1'b0;
    accept  = 1'b0;

    if (samp_q) begin
      if (!legal) begin
        cerr_d  = 1'b1;
        err_inc = 1'b1;
        state_d = UNLOCKED;
        cnt_d   = '0;
      end else begin
        prev_d = smp_bcd;
        if (smp_bcd == prev_q)
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + cnt_t'(1);
        else
          cnt_d = cnt_t'(1);
        // A value is accepted once when the count first reaches the threshold;
        // with a threshold of one every legal sample (even a repeat) counts.
        accept = (STABLE_CYCLES == 1) || ((cnt_d == CNT_MAX) && (cnt_q != CNT_MAX));
        if (accept) begin
          valid_d = 1'b1;
          bcd_d   = smp_bcd;
          bin_d   = smp_bin;
          ref_d   = smp_bin;
          case (state_q)
            UNLOCKED: state_d = ACQ;
            ACQ:      if (smp_bin == ref_inc) state_d = LOCKED;
            LOCKED: begin
              if (smp_bin != ref_inc) begin
                serr_d  = 1'b1;
                err_inc = 1'b1;
                state_d = ACQ;
              end
            end
            default:  state_d = UNLOCKED;
          endcase
        end
      end
    end

    err_d = err_q;
    if (err_inc && (err_q != '1))
      err_d = err_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q   <= '0;
      samp_q  <= 1'b0;
      state_q <= UNLOCKED;
      cnt_q   <= '0;
      prev_q  <= '0;
      ref_q   <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
      valid_q <= 1'b0;
      cerr_q  <= 1'b0;
      serr_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      if (sample_en) seg_q <= seg_in;
      samp_q  <= sample_en;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      ref_q   <= ref_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      valid_q <= valid_d;
      cerr_q  <= cerr_d;
      serr_q  <= serr_d;
      err_q   <= err_d;
    end
  end

  assign bcd_out   = bcd_q;
  assign bin_out   = bin_q;
  assign valid     = valid_q;
  assign code_err  = cerr_q;
  assign seq_err   = serr_q;
  assign locked    = (state_q == LOCKED);
  assign err_count = err_q;

endmodule
